// File: rtl/inv_cipher_iter.sv
// Purpose  : iterative AES inverse cipher (AES-128/192/256 via NK), one round per clock
//            (two rounds per clock when INV_CIPHER_2RPC_EN is defined).
// Latency  : accept cycle T -> out_valid in cycle T+NR+1 (T+NR/2+1 with INV_CIPHER_2RPC_EN).
// Backpres.: result held in DONE until out_ready; next block accepted in the same cycle
//            as the output handshake, so streaming throughput is one block per latency period.
// Ports    : clk/rst (async, active-high); in_valid/in_ready/in_data ciphertext in;
//            ik_sch expanded key, round key 0 in the MS 128-bit slice;
//            out_valid/out_ready/out_data plaintext out; busy high while rounds run.
// Macro    : INV_CIPHER_2RPC_EN selects two chained rounds per BUSY cycle.
module inv_cipher_iter #(
  parameter int NK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in_data,
  input  logic [(NK+7)*128-1:0]   ik_sch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data,
  output logic                    busy
);
  localparam int NR = NK + 6;
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("inv_cipher_iter: NK must be 4, 6 or 8");
  end

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (only 9/b/d/e are used).
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return ({8{k[0]}} & b) ^ ({8{k[1]}} & b2) ^ ({8{k[2]}} & b4) ^ ({8{k[3]}} & b8);
  endfunction

  // One round: InvMixColumns is deferred to the start of the following round, so the
  // first round skips it and the last round naturally ends with AddRoundKey(key 0).
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic mix,
                                             input logic [127:0] rk);
    logic [127:0] t;
    logic [127:0] u;
    logic [7:0]   a0, a1, a2, a3;
    t = s;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s[127-32*c -: 8];
        a1 = s[119-32*c -: 8];
        a2 = s[111-32*c -: 8];
        a3 = s[103-32*c -: 8];
        t[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
        t[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
        t[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
        t[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
      end
    end
    u = '0;
    // Row r shifts right by r: out[r][c] = in[r][(c-r) mod 4], byte index r+4c.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        u[127-8*(r+4*c) -: 8] = inv_sbox(t[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return u ^ rk;
  endfunction

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_rnd;
  logic [127:0]   r_st;
  logic           w_in_ready, w_accept;
  logic [127:0]   w_st_rnd, w_r0;

  // Round keys indexed by key number; padded to 16 so any 4-bit index is in range.
  logic [127:0]   w_rk [16];
  for (genvar k = 0; k < 16; k++) begin : g_rk
    if (k <= NR) begin : g_key
      assign w_rk[k] = ik_sch[(NR-k)*128 +: 128];
    end else begin : g_pad
      assign w_rk[k] = '0;
    end
  end

  // Round i uses key NR-1-i.
  assign w_r0 = inv_round(r_st, r_rnd != 4'd0, w_rk[NR_M1 - r_rnd]);

`ifdef INV_CIPHER_2RPC_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  localparam logic [3:0] RND_LAST = 4'(NR - 2);
  logic [127:0] w_r1;
  assign w_r1     = inv_round(w_r0, 1'b1, w_rk[NR_M1 - r_rnd - 4'd1]);
  assign w_st_rnd = w_r1;
`else
  localparam logic [3:0] RND_STEP = 4'd1;
  localparam logic [3:0] RND_LAST = NR_M1;
  assign w_st_rnd = w_r0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_BUSY: if (r_rnd == RND_LAST) w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          w_in_ready  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_accept = w_in_ready && in_valid;
    if (w_accept) w_state_nxt = S_BUSY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rnd   <= 4'd0;
      r_st    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_st  <= in_data ^ w_rk[NR];
        r_rnd <= 4'd0;
      end else if (r_state == S_BUSY) begin
        r_st  <= w_st_rnd;
        // Hold at the last round index rather than stepping past NR-1.
        r_rnd <= (r_rnd == RND_LAST) ? r_rnd : r_rnd + RND_STEP;
      end
    end
  end

  assign in_ready  = w_in_ready && !rst;
  assign busy      = (r_state == S_BUSY);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = (r_state == S_DONE) ? r_st : '0;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Purpose  : directed checks of inv_cipher_iter for NK=4/6/8 with FIPS-197 vectors.
// Latency  : expected out_valid cycle derived from NR (halved rounds with INV_CIPHER_2RPC_EN).
// Backpres.: exercises output stall, same-cycle re-accept, streaming and mid-block reset.
module tb_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]   iv, ord, ir, ov, bz;
  logic [127:0] id [3];
  logic [127:0] od [3];
  logic [1407:0] ks4;
  logic [1663:0] ks6;
  logic [1919:0] ks8;
  logic [127:0] ct [3];
  logic [7:0]   sb [256];

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  int checks = 0;
  int errors = 0;

  inv_cipher_iter #(.NK(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .ik_sch(ks4), .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .busy(bz[0]));
  inv_cipher_iter #(.NK(6)) u6 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .ik_sch(ks6), .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .busy(bz[1]));
  inv_cipher_iter #(.NK(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .ik_sch(ks8), .out_valid(ov[2]), .out_ready(ord[2]), .out_data(od[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt8(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // FIPS-197 key expansion for key bytes 00,01,02,...; word 0 lands in the MSBs.
  function automatic logic [1919:0] expand(input int nk);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            nr;
    nr  = nk + 6;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt8(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 4*(nr+1); i++) res[1919-32*i -: 32] = w[i];
    return res;
  endfunction

  function automatic int exp_lat(input int n);
    int nr;
    nr = 10 + 2*n;
`ifdef INV_CIPHER_2RPC_EN
    return nr/2 + 1;
`else
    return nr + 1;
`endif
  endfunction

  // One block through instance n with out_ready held high.
  task automatic do_block(input int n, input string tag);
    int lat;
    @(negedge clk);
    id[n] = ct[n]; iv[n] = 1'b1; ord[n] = 1'b1;
    #1 chk({tag, "_in_ready"}, ir[n], 1'b1);
    @(negedge clk);
    iv[n] = 1'b0; id[n] = '0;
    lat = 1;
    chk({tag, "_busy"}, bz[n], 1'b1);
    while (ov[n] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat(n));
    chk({tag, "_data"}, od[n], PT);
    chk({tag, "_busy_done"}, bz[n], 1'b0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, ov[n], 1'b0);
  endtask

  initial begin
    int t_prev, seen, guard, any;
    logic [1919:0] full;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = '0;
      if (a != 0)
        for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    full = expand(4); ks4 = full[1919 -: 1408];
    full = expand(6); ks6 = full[1919 -: 1664];
    full = expand(8); ks8 = full;
    ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    iv = '0; ord = '0;
    for (int i = 0; i < 3; i++) id[i] = '0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", ir, 3'b000);
    chk("rst_out_valid", ov, 3'b000);
    chk("rst_busy", bz, 3'b000);
    chk("rst_out_data", od[0], '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", ir, 3'b111);

    // T1..T3 (T6 when built with INV_CIPHER_2RPC_EN)
    do_block(0, "t1_nk4");
    do_block(1, "t2_nk6");
    do_block(2, "t3_nk8");

    // T4: output stall, same-cycle re-accept, streaming
    @(negedge clk);
    id[0] = ct[0]; iv[0] = 1'b1; ord[0] = 1'b0;
    guard = 0;
    while (ov[0] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t4_stall_valid", ov[0], 1'b1);
      chk("t4_stall_data", od[0], PT);
      chk("t4_stall_in_ready", ir[0], 1'b0);
    end
    @(negedge clk);
    ord[0] = 1'b1;
    #1 chk("t4_release_in_ready", ir[0], 1'b1);
    t_prev = cyc;
    @(negedge clk);
    chk("t4_reaccept_valid", ov[0], 1'b0);
    chk("t4_reaccept_busy", bz[0], 1'b1);
    seen = 0; guard = 0;
    while (seen < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (ov[0] === 1'b1) begin
        chk("t4_stream_period", cyc - t_prev, exp_lat(0));
        chk("t4_stream_data", od[0], PT);
        t_prev = cyc;
        seen++;
        if (seen == 3) iv[0] = 1'b0;
      end
    end
    chk("t4_stream_count", seen, 3);
    repeat (2) @(negedge clk);
    chk("t4_idle_valid", ov[0], 1'b0);
    chk("t4_idle_busy", bz[0], 1'b0);

    // T5: reset during the 4th BUSY cycle
    @(negedge clk);
    id[0] = ct[0]; iv[0] = 1'b1; ord[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_before", bz[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", ov[0], 1'b0);
    chk("t5_rst_busy", bz[0], 1'b0);
    chk("t5_rst_in_ready", ir[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_valid", ov[0], 1'b0);
    chk("t5_after_busy", bz[0], 1'b0);
    chk("t5_after_in_ready", ir[0], 1'b1);
    any = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) any = 1;
    end
    chk("t5_no_output", any, 0);
    do_block(0, "t5_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
